// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types, sizes and direction helper for the snake game sequencer.
package snake_pkg;

  localparam int GRID_W          = 3;
  localparam int IDX_W           = 2 * GRID_W;
  localparam int FOOD_CANDIDATES = 5;
  localparam logic [7:0] SCORE_MAX = 8'hFF;

  typedef enum logic [1:0] {
    DIR_R = 2'b00,
    DIR_D = 2'b01,
    DIR_L = 2'b10,
    DIR_U = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } run_state_t;

  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_food_pick.sv
// rtl/snake_food_pick.sv - picks the first free cell among lfsr+0..lfsr+4 for new food.
module snake_food_pick
  import snake_pkg::*;
(
  input  logic [IDX_W-1:0] lfsr,
  input  logic [IDX_W-1:0] head_next,
  input  logic [IDX_W-1:0] head,
  input  logic [IDX_W-1:0] body0,
  input  logic [IDX_W-1:0] body1,
  output logic [IDX_W-1:0] food_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Five candidates against four occupied cells, so a free one always exists.
  always_comb begin
    food_idx = lfsr + IDX_W'(FOOD_CANDIDATES - 1);
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < FOOD_CANDIDATES; k++) begin
      cand = lfsr + IDX_W'(k);
      if (!found && cand != head_next && cand != head && cand != body0 && cand != body1) begin
        food_idx = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// rtl/snake_ctrl.sv - game FSM, tick divider, direction latch, next-head math and scoring.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int         TICK_DIV  = 4,
  parameter int         WRAP      = 1,
  parameter logic [5:0] LFSR_SEED = 6'h2D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_pause,
  input  logic             btn_dir_valid,
  input  logic [1:0]       btn_dir,
  input  logic [1:0]       dir,
  input  logic [IDX_W-1:0] idx_head,
  input  logic [IDX_W-1:0] idx0,
  input  logic [IDX_W-1:0] idx1,
  input  logic [IDX_W-1:0] idx_food,
  input  logic             game_over,
  output logic             step,
  output logic             state_rst,
  output logic [1:0]       next_dir,
  output logic [IDX_W-1:0] idx_head_next,
  output logic             eat,
  output logic             hit_body,
  output logic [IDX_W-1:0] new_food_idx,
  output logic [7:0]       score,
  output logic [1:0]       run_state
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  run_state_t        st;
  dir_t              pending_dir;
  logic [TICK_W-1:0] tick_cnt;
  logic [IDX_W-1:0]  lfsr;
  logic              pause_q;
  logic              pause_rise;
  logic [GRID_W-1:0] hx, hy, nx, ny;
  logic              at_edge;
  logic              wall;

  assign pause_rise = btn_pause & ~pause_q;
  assign hx = idx_head[GRID_W-1:0];
  assign hy = idx_head[IDX_W-1:GRID_W];

  always_comb begin
    nx      = hx;
    ny      = hy;
    at_edge = 1'b0;
    unique case (pending_dir)
      DIR_R: begin nx = hx + 3'd1; at_edge = (hx == 3'd7); end
      DIR_D: begin ny = hy + 3'd1; at_edge = (hy == 3'd7); end
      DIR_L: begin nx = hx - 3'd1; at_edge = (hx == 3'd0); end
      DIR_U: begin ny = hy - 3'd1; at_edge = (hy == 3'd0); end
    endcase
  end

  assign wall          = (WRAP == 0) && at_edge;
  assign idx_head_next = {ny, nx};
  assign next_dir      = pending_dir;
  assign run_state     = st;
  assign eat           = step & (idx_head_next == idx_food);
  assign hit_body      = step & (wall | (idx_head_next == idx0) | (idx_head_next == idx1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_q <= 1'b0;
      lfsr    <= LFSR_SEED;
    end else begin
      pause_q <= btn_pause;
      lfsr    <= {lfsr[IDX_W-2:0], lfsr[5] ^ lfsr[4]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_IDLE;
      tick_cnt    <= '0;
      pending_dir <= DIR_R;
      score       <= '0;
      step        <= 1'b0;
      state_rst   <= 1'b0;
    end else begin
      step      <= 1'b0;
      state_rst <= 1'b0;
      if (btn_dir_valid && (btn_dir != dir_opposite(dir_t'(dir))))
        pending_dir <= dir_t'(btn_dir);
      if (eat && score != SCORE_MAX)
        score <= score + 8'd1;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (btn_start) begin
            st          <= ST_RUN;
            state_rst   <= 1'b1;
            tick_cnt    <= '0;
            score       <= '0;
            pending_dir <= DIR_R;
          end
        end
        ST_RUN: begin
          // game_over may still read stale while the state register is being restarted.
          if (game_over && !state_rst) begin
            st <= ST_OVER;
          end else if (pause_rise) begin
            st <= ST_PAUSE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            step     <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (pause_rise) st <= ST_RUN;
        end
      endcase
    end
  end

  snake_food_pick u_food_pick (
    .lfsr      (lfsr),
    .head_next (idx_head_next),
    .head      (idx_head),
    .body0     (idx0),
    .body1     (idx1),
    .food_idx  (new_food_idx)
  );

endmodule

// File: tb/tb_snake_ctrl.sv
// tb/tb_snake_ctrl.sv - directed, table-driven self-checking bench for snake_ctrl.
module tb_snake_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_dir_valid = 1'b0;
  logic [1:0] btn_dir = 2'b00, dir = 2'b00;
  logic [5:0] idx_head = 6'd27, idx0 = 6'd26, idx1 = 6'd25, idx_food = 6'd63;
  logic       game_over = 1'b0;

  logic       step, state_rst, eat, hit_body;
  logic [1:0] next_dir, run_state;
  logic [5:0] idx_head_next, new_food_idx;
  logic [7:0] score;

  logic       w_step, w_state_rst, w_eat, w_hit_body;
  logic [1:0] w_next_dir, w_run_state;
  logic [5:0] w_idx_head_next, w_new_food_idx;
  logic [7:0] w_score;

  logic [5:0] m_lfsr;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 6'h2D;
    else     m_lfsr <= {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};

  snake_ctrl #(.TICK_DIV(4), .WRAP(1), .LFSR_SEED(6'h2D)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_dir_valid(btn_dir_valid), .btn_dir(btn_dir), .dir(dir), .idx_head(idx_head),
    .idx0(idx0), .idx1(idx1), .idx_food(idx_food), .game_over(game_over),
    .step(step), .state_rst(state_rst), .next_dir(next_dir), .idx_head_next(idx_head_next),
    .eat(eat), .hit_body(hit_body), .new_food_idx(new_food_idx), .score(score),
    .run_state(run_state)
  );

  snake_ctrl #(.TICK_DIV(4), .WRAP(0), .LFSR_SEED(6'h2D)) dut_w (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_dir_valid(btn_dir_valid), .btn_dir(btn_dir), .dir(dir), .idx_head(idx_head),
    .idx0(idx0), .idx1(idx1), .idx_food(idx_food), .game_over(game_over),
    .step(w_step), .state_rst(w_state_rst), .next_dir(w_next_dir), .idx_head_next(w_idx_head_next),
    .eat(w_eat), .hit_body(w_hit_body), .new_food_idx(w_new_food_idx), .score(w_score),
    .run_state(w_run_state)
  );

  typedef struct {
    logic [1:0] cur_dir;
    logic [1:0] req;
    logic [5:0] head;
    logic [1:0] exp_nd;
    logic [5:0] exp_next;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 64);
    check("step_seen", {31'd0, step}, 1);
  endtask

  task automatic step_advance(input logic [5:0] h, input logic [5:0] b0, input logic [5:0] b1);
    @(posedge clk);
    #1;
    idx_head = h;
    idx0 = b0;
    idx1 = b1;
  endtask

  initial begin
    int n, steps, eats, cyc;
    logic [5:0] l;
    logic ok;

    vecs[0] = '{2'b00, 2'b01, 6'd27, 2'b01, 6'd35};
    vecs[1] = '{2'b01, 2'b11, 6'd27, 2'b01, 6'd35};
    vecs[2] = '{2'b01, 2'b00, 6'd31, 2'b00, 6'd24};
    vecs[3] = '{2'b00, 2'b10, 6'd40, 2'b00, 6'd41};
    vecs[4] = '{2'b01, 2'b10, 6'd40, 2'b10, 6'd47};
    vecs[5] = '{2'b00, 2'b11, 6'd2,  2'b11, 6'd58};
    vecs[6] = '{2'b10, 2'b01, 6'd58, 2'b01, 6'd2};
    vecs[7] = '{2'b11, 2'b01, 6'd54, 2'b01, 6'd62};
    vecs[8] = '{2'b11, 2'b00, 6'd21, 2'b00, 6'd22};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_run_state", {30'd0, run_state}, 0);
    check("rst_step", {31'd0, step}, 0);
    check("rst_state_rst", {31'd0, state_rst}, 0);
    check("rst_score", {24'd0, score}, 0);
    check("rst_next_dir", {30'd0, next_dir}, 0);
    rst = 1'b0;

    // Direction latch and next-head table, in IDLE
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      dir = vecs[i].cur_dir;
      btn_dir = vecs[i].req;
      btn_dir_valid = 1'b1;
      idx_head = vecs[i].head;
      @(negedge clk);
      btn_dir_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_next_dir", i), {30'd0, next_dir}, {30'd0, vecs[i].exp_nd});
      check($sformatf("vec%0d_head_next", i), {26'd0, idx_head_next}, {26'd0, vecs[i].exp_next});
    end

    // Start: state_rst pulse, first step TICK_DIV cycles later
    dir = 2'b00; idx_head = 6'd27; idx0 = 6'd26; idx1 = 6'd25; idx_food = 6'd63;
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    check("start_state_rst", {31'd0, state_rst}, 1);
    check("start_run_state", {30'd0, run_state}, 1);
    check("start_step", {31'd0, step}, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("first_step_c%0d", c), {31'd0, step}, {31'd0, c == 4});
    end
    check("state_rst_one_clk", {31'd0, state_rst}, 0);
    check("step1_head_next", {26'd0, idx_head_next}, 28);
    check("step1_eat", {31'd0, eat}, 0);
    check("step1_hit", {31'd0, hit_body}, 0);
    step_advance(6'd28, 6'd27, 6'd26);
    wait_step(n);
    check("step2_period", n, 4);
    check("step2_head_next", {26'd0, idx_head_next}, 29);
    step_advance(6'd29, 6'd28, 6'd27);
    wait_step(n);
    check("step3_period", n, 4);
    check("step3_head_next", {26'd0, idx_head_next}, 30);

    // Reversal rejected, last legal request wins, request in step cycle deferred
    step_advance(6'd30, 6'd29, 6'd28);
    @(negedge clk);
    btn_dir = 2'b10; btn_dir_valid = 1'b1;
    @(negedge clk);
    check("reversal_dropped", {30'd0, next_dir}, 0);
    btn_dir = 2'b01;
    @(negedge clk);
    check("req_01", {30'd0, next_dir}, 1);
    btn_dir = 2'b11;
    @(negedge clk);
    btn_dir_valid = 1'b0;
    check("step4_on_time", {31'd0, step}, 1);
    check("last_req_wins", {30'd0, next_dir}, 3);
    check("step4_head_next", {26'd0, idx_head_next}, 22);
    btn_dir = 2'b00; btn_dir_valid = 1'b1;
    #1;
    check("step_cycle_req_deferred", {30'd0, next_dir}, 3);
    step_advance(6'd22, 6'd30, 6'd29);
    btn_dir_valid = 1'b0; dir = 2'b11;
    check("step_cycle_req_applied", {30'd0, next_dir}, 0);
    wait_step(n);
    check("step5_head_next", {26'd0, idx_head_next}, 23);

    // Eat
    step_advance(6'd44, 6'd43, 6'd42);
    idx_food = 6'd45; dir = 2'b00;
    wait_step(n);
    check("eat_period", n, 4);
    check("eat", {31'd0, eat}, 1);
    check("eat_no_hit", {31'd0, hit_body}, 0);
    ok = (new_food_idx != 6'd45) && (new_food_idx != 6'd44) &&
         (new_food_idx != 6'd43) && (new_food_idx != 6'd42);
    check("eat_food_free", {31'd0, ok}, 1);
    step_advance(6'd45, 6'd44, 6'd43);
    idx_food = 6'd63;
    check("eat_score", {24'd0, score}, 1);

    // Pause mid-count holds tick_cnt
    @(negedge clk);
    @(negedge clk);
    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
    check("paused", {30'd0, run_state}, 2);
    steps = 0;
    repeat (8) begin
      @(negedge clk);
      if (step) steps++;
    end
    check("pause_no_step", steps, 0);
    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
    check("resumed", {30'd0, run_state}, 1);
    check("resume_c1_step", {31'd0, step}, 0);
    @(negedge clk);
    check("resume_c2_step", {31'd0, step}, 0);
    @(negedge clk);
    check("resume_c3_step", {31'd0, step}, 1);
    check("resume_head_next", {26'd0, idx_head_next}, 46);

    // Edge crossing: wrap vs wall
    step_advance(6'd31, 6'd30, 6'd29);
    wait_step(n);
    check("wrap_head_next", {26'd0, idx_head_next}, 24);
    check("wrap_no_hit", {31'd0, hit_body}, 0);
    check("wall_hit", {31'd0, w_hit_body}, 1);
    check("wall_step", {31'd0, w_step}, 1);
    check("wall_score", {24'd0, w_score}, 1);
    check("wall_state_rst", {31'd0, w_state_rst}, 0);
    check("wall_next_dir", {30'd0, w_next_dir}, 0);
    check("wall_eat", {31'd0, w_eat}, 0);
    ok = (w_new_food_idx != 6'd24) && (w_new_food_idx != 6'd31) &&
         (w_new_food_idx != 6'd30) && (w_new_food_idx != 6'd29);
    check("wall_food_free", {31'd0, ok}, 1);
    @(posedge clk);
    #1;
    game_over = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("over", {30'd0, run_state}, 3);
    check("wall_over", {30'd0, w_run_state}, 3);
    steps = 0;
    repeat (6) begin
      @(negedge clk);
      if (step) steps++;
    end
    check("over_no_step", steps, 0);

    // Food search with the first candidates occupied
    n = 0;
    do begin
      @(negedge clk);
      l = m_lfsr;
      n++;
    end while (l[2:0] == 3'd7 && n < 8);
    idx_head = l; idx0 = l + 6'd2; idx1 = l + 6'd3;
    #1;
    check("food_skip4", {26'd0, new_food_idx}, {26'd0, l + 6'd4});
    idx_head = l + 6'd32; idx0 = l + 6'd1; idx1 = l + 6'd40;
    #1;
    check("food_first", {26'd0, new_food_idx}, {26'd0, l});
    idx0 = l; idx1 = l + 6'd1;
    #1;
    check("food_skip2", {26'd0, new_food_idx}, {26'd0, l + 6'd2});

    // Restart from OVER
    @(negedge clk);
    btn_dir = 2'b01; btn_dir_valid = 1'b1;
    @(negedge clk);
    btn_dir_valid = 1'b0;
    check("over_req", {30'd0, next_dir}, 1);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    game_over = 1'b0;
    check("restart_state_rst", {31'd0, state_rst}, 1);
    check("restart_run_state", {30'd0, run_state}, 1);
    check("restart_score", {24'd0, score}, 0);
    check("restart_next_dir", {30'd0, next_dir}, 0);
    @(negedge clk);
    check("restart_pulse_end", {31'd0, state_rst}, 0);
    check("restart_still_run", {30'd0, run_state}, 1);

    // Reset mid-game
    wait_step(n);
    check("restart_first_step", n, 3);
    rst = 1'b1;
    #1;
    check("midrst_step", {31'd0, step}, 0);
    check("midrst_run_state", {30'd0, run_state}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {30'd0, run_state}, 0);
    check("midrst_no_step", {31'd0, step}, 0);

    // Score saturation
    idx_head = 6'd44; idx0 = 6'd43; idx1 = 6'd42; idx_food = 6'd45; dir = 2'b00;
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    eats = 0;
    cyc = 0;
    while (eats < 256 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (eat) eats++;
    end
    check("sat_eats", eats, 256);
    @(negedge clk);
    check("score_saturated", {24'd0, score}, 255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
